// File: rtl/cmos_pixel_capture.sv
// cmos_pixel_capture
//   Samples a parallel CMOS camera bus (pclk/href/vsync/db) on clk_100,
//   assembles bytes into pixels, applies frame decimation and a crop
//   window, and presents pixels on a one-deep valid/ready output register.
//
//   State | meaning
//   ------+---------------------------------------------------------
//   IDLE    | capture disabled
//   WAIT_VS | armed, waiting for vsync fall (start of frame)
//   ACTIVE  | capturing the current frame
//   SKIP    | current frame is decimated away
//
// Ports
//   clk_100, rst_n            system clock, async active-low reset
//   cmos_pclk/href/vsync/db   raw camera bus, asynchronous to clk_100
//   enable, decim             capture enable, frames skipped per capture
//   crop_x0/x1/y0/y1          inclusive crop window (pixel/line)
//   pix_data/valid/sof/eol    pixel output, first byte in the MSBs
//   pix_ready                 downstream accept
//   frame_cnt, overflow_cnt   captured frames, dropped pixels
//   busy                      state is not IDLE
//
// BYTES_PER_PIXEL must be 1 or 2.

module cmos_pixel_capture #(
    parameter int BYTES_PER_PIXEL = 2,
    parameter int CNT_W           = 10
) (
    input  logic                         clk_100,
    input  logic                         rst_n,
    input  logic                         cmos_pclk,
    input  logic                         cmos_href,
    input  logic                         cmos_vsync,
    input  logic [7:0]                   cmos_db,
    input  logic                         enable,
    input  logic [3:0]                   decim,
    input  logic [CNT_W-1:0]             crop_x0,
    input  logic [CNT_W-1:0]             crop_x1,
    input  logic [CNT_W-1:0]             crop_y0,
    input  logic [CNT_W-1:0]             crop_y1,
    output logic [8*BYTES_PER_PIXEL-1:0] pix_data,
    output logic                         pix_valid,
    output logic                         pix_sof,
    output logic                         pix_eol,
    input  logic                         pix_ready,
    output logic [15:0]                  frame_cnt,
    output logic [15:0]                  overflow_cnt,
    output logic                         busy
);

    localparam int PW  = 8 * BYTES_PER_PIXEL;
    localparam int BIW = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
    localparam logic [BIW-1:0] LAST_IDX = BIW'(BYTES_PER_PIXEL - 1);

    typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE, SKIP} state_t;

    logic             pclk_s1_q, pclk_s2_q;
    logic             href_s1_q, href_s2_q;
    logic             vsync_s1_q, vsync_s2_q;
    logic [7:0]       db_q;

    logic [BIW-1:0]   byte_idx_q;
    logic [BIW-1:0]   lane;
    logic [PW-1:0]    asm_q, asm_d;
    logic [CNT_W-1:0] col_q, row_q;

    state_t           state_q;
    logic [3:0]       skip_cnt_q;
    logic [15:0]      frame_cnt_q;
    logic             sof_pend_q;
    logic             busy_q;
    logic [CNT_W-1:0] cx0_q, cx1_q, cy0_q, cy1_q;

    logic [PW-1:0]    pix_data_q;
    logic             pix_valid_q, pix_sof_q, pix_eol_q;
    logic [15:0]      ovf_q;

    logic pclk_rise, href_fall, vsync_fall, vsync_rise;
    logic cap_byte, pix_done, in_crop, emit;

    // Two-flop synchronisers; data registered once, alongside s1, so the
    // byte seen at a detected pclk rise was sampled with pclk already high.
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            pclk_s1_q  <= 1'b0;
            pclk_s2_q  <= 1'b0;
            href_s1_q  <= 1'b0;
            href_s2_q  <= 1'b0;
            vsync_s1_q <= 1'b0;
            vsync_s2_q <= 1'b0;
            db_q       <= '0;
        end else begin
            pclk_s1_q  <= cmos_pclk;
            pclk_s2_q  <= pclk_s1_q;
            href_s1_q  <= cmos_href;
            href_s2_q  <= href_s1_q;
            vsync_s1_q <= cmos_vsync;
            vsync_s2_q <= vsync_s1_q;
            db_q       <= cmos_db;
        end
    end

    assign pclk_rise  = pclk_s1_q & ~pclk_s2_q;
    assign href_fall  = ~href_s1_q & href_s2_q;
    assign vsync_fall = ~vsync_s1_q & vsync_s2_q;
    assign vsync_rise = vsync_s1_q & ~vsync_s2_q;

    assign cap_byte = pclk_rise & href_s1_q & href_s2_q;
    assign pix_done = cap_byte & (byte_idx_q == LAST_IDX);

    // Byte 0 lands in the top lane so the first byte ends up in the MSBs.
    assign lane = LAST_IDX - byte_idx_q;

    always_comb begin
        asm_d              = asm_q;
        asm_d[lane*8 +: 8] = db_q;
    end

    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx_q <= '0;
            asm_q      <= '0;
            col_q      <= '0;
            row_q      <= '0;
        end else begin
            if (href_fall)
                byte_idx_q <= '0;
            else if (cap_byte)
                byte_idx_q <= (byte_idx_q == LAST_IDX) ? '0 : byte_idx_q + 1'b1;
            if (cap_byte)
                asm_q <= asm_d;
            if (href_fall)
                col_q <= '0;
            else if (pix_done && (col_q != '1))
                col_q <= col_q + 1'b1;
            if (vsync_fall)
                row_q <= '0;
            else if (href_fall && (row_q != '1))
                row_q <= row_q + 1'b1;
        end
    end

    assign in_crop = (col_q >= cx0_q) && (col_q <= cx1_q) &&
                     (row_q >= cy0_q) && (row_q <= cy1_q);
    assign emit    = pix_done && (state_q == ACTIVE) && in_crop;

    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            skip_cnt_q  <= '0;
            frame_cnt_q <= '0;
            sof_pend_q  <= 1'b0;
            busy_q      <= 1'b0;
            cx0_q       <= '0;
            cx1_q       <= '0;
            cy0_q       <= '0;
            cy1_q       <= '0;
        end else begin
            // Window is frozen for the whole frame.
            if (vsync_fall) begin
                cx0_q <= crop_x0;
                cx1_q <= crop_x1;
                cy0_q <= crop_y0;
                cy1_q <= crop_y1;
            end
            if (emit)
                sof_pend_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q <= WAIT_VS;
                        busy_q  <= 1'b1;
                    end
                end
                WAIT_VS: begin
                    if (!enable) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (vsync_fall) begin
                        if (skip_cnt_q == 4'd0) begin
                            state_q    <= ACTIVE;
                            skip_cnt_q <= decim;
                            sof_pend_q <= 1'b1;
                        end else begin
                            state_q    <= SKIP;
                            skip_cnt_q <= skip_cnt_q - 4'd1;
                        end
                    end
                end
                ACTIVE, SKIP: begin
                    // Disable only lands at a frame boundary.
                    if (vsync_rise) begin
                        state_q <= enable ? WAIT_VS : IDLE;
                        busy_q  <= enable;
                        if (state_q == ACTIVE)
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // One-deep output register; a new pixel replaces the held one only
    // when the held one is accepted in the same cycle.
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
            pix_sof_q   <= 1'b0;
            pix_eol_q   <= 1'b0;
            ovf_q       <= '0;
        end else begin
            if (emit && (!pix_valid_q || pix_ready)) begin
                pix_data_q  <= asm_d;
                pix_valid_q <= 1'b1;
                pix_sof_q   <= sof_pend_q;
                pix_eol_q   <= (col_q == cx1_q);
            end else if (pix_valid_q && pix_ready) begin
                pix_valid_q <= 1'b0;
            end
            if (emit && pix_valid_q && !pix_ready && (ovf_q != 16'hFFFF))
                ovf_q <= ovf_q + 16'd1;
        end
    end

    assign pix_data     = pix_data_q;
    assign pix_valid    = pix_valid_q;
    assign pix_sof      = pix_sof_q;
    assign pix_eol      = pix_eol_q;
    assign frame_cnt    = frame_cnt_q;
    assign overflow_cnt = ovf_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_cmos_pixel_capture.sv
// Bench for cmos_pixel_capture: one instance with 2 bytes/pixel, one with
// 1 byte/pixel, sharing the camera bus; only one is enabled at a time.
module tb_cmos_pixel_capture;

    logic clk_100 = 1'b0;
    always #5 clk_100 = ~clk_100;

    logic       rst_n, cmos_pclk, cmos_href, cmos_vsync;
    logic [7:0] cmos_db;
    logic       en_a, en_b, rdy;
    logic [3:0] decim;
    logic [9:0] cx0, cx1, cy0, cy1;

    logic [15:0] a_data;
    logic        a_valid, a_sof, a_eol, a_busy;
    logic [15:0] a_frame, a_ovf;
    logic [7:0]  b_data;
    logic        b_valid, b_sof, b_eol, b_busy;
    logic [15:0] b_frame, b_ovf;

    cmos_pixel_capture #(.BYTES_PER_PIXEL(2), .CNT_W(10)) dut_a (
        .clk_100(clk_100), .rst_n(rst_n), .cmos_pclk(cmos_pclk),
        .cmos_href(cmos_href), .cmos_vsync(cmos_vsync), .cmos_db(cmos_db),
        .enable(en_a), .decim(decim), .crop_x0(cx0), .crop_x1(cx1),
        .crop_y0(cy0), .crop_y1(cy1), .pix_data(a_data), .pix_valid(a_valid),
        .pix_sof(a_sof), .pix_eol(a_eol), .pix_ready(rdy), .frame_cnt(a_frame),
        .overflow_cnt(a_ovf), .busy(a_busy));

    cmos_pixel_capture #(.BYTES_PER_PIXEL(1), .CNT_W(10)) dut_b (
        .clk_100(clk_100), .rst_n(rst_n), .cmos_pclk(cmos_pclk),
        .cmos_href(cmos_href), .cmos_vsync(cmos_vsync), .cmos_db(cmos_db),
        .enable(en_b), .decim(decim), .crop_x0(cx0), .crop_x1(cx1),
        .crop_y0(cy0), .crop_y1(cy1), .pix_data(b_data), .pix_valid(b_valid),
        .pix_sof(b_sof), .pix_eol(b_eol), .pix_ready(rdy), .frame_cnt(b_frame),
        .overflow_cnt(b_ovf), .busy(b_busy));

    logic        sel;
    logic [15:0] m_data, m_frame, m_ovf;
    logic        m_valid, m_sof, m_eol, m_busy;
    assign m_data  = sel ? {8'h00, b_data} : a_data;
    assign m_valid = sel ? b_valid : a_valid;
    assign m_sof   = sel ? b_sof   : a_sof;
    assign m_eol   = sel ? b_eol   : a_eol;
    assign m_busy  = sel ? b_busy  : a_busy;
    assign m_frame = sel ? b_frame : a_frame;
    assign m_ovf   = sel ? b_ovf   : a_ovf;

    typedef struct {
        logic [15:0] data;
        logic        sof;
        logic        eol;
    } pix_t;

    typedef struct {
        bit          sel;
        logic [9:0]  x0, x1, y0, y1;
        logic [3:0]  dec;
        int          ncols, nrows, nframes;
        int          exp_pix;
        logic [15:0] exp_frames;
        logic [15:0] exp_first;
    } vec_t;

    pix_t        exp_q[$];
    pix_t        mon_e, held;
    bit          hold_prev;
    int          n_checks, n_err, pop_count, exp_ovf, bpp, pc0;
    logic [15:0] first_data;
    bit          first_seen, sof_pend;
    logic [7:0]  bval;
    vec_t        vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard sink: sampled half a cycle away from the active edge.
    always @(negedge clk_100) begin
        #1;
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", {31'd0, m_valid}, 32'd1);
                check("hold_data", {16'd0, m_data}, {16'd0, held.data});
                check("hold_sof", {31'd0, m_sof}, {31'd0, held.sof});
                check("hold_eol", {31'd0, m_eol}, {31'd0, held.eol});
            end
            hold_prev = 1'b0;
            if (m_valid && !rdy) begin
                hold_prev = 1'b1;
                held.data = m_data;
                held.sof  = m_sof;
                held.eol  = m_eol;
            end
            if (m_valid && rdy) begin
                pop_count++;
                if (!first_seen) begin
                    first_seen = 1'b1;
                    first_data = m_data;
                end
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_pixel actual=%0h required=none", m_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pix_data", {16'd0, m_data}, {16'd0, mon_e.data});
                    check("pix_sof", {31'd0, m_sof}, {31'd0, mon_e.sof});
                    check("pix_eol", {31'd0, m_eol}, {31'd0, mon_e.eol});
                end
            end
        end
    end

    task automatic set_en(input logic v);
        if (sel) en_b = v;
        else     en_a = v;
    endtask

    task automatic apply_reset();
        @(negedge clk_100);
        rst_n      = 1'b0;
        en_a       = 1'b0;
        en_b       = 1'b0;
        cmos_pclk  = 1'b0;
        cmos_href  = 1'b0;
        cmos_vsync = 1'b0;
        repeat (3) @(negedge clk_100);
        exp_q.delete();
        pop_count  = 0;
        exp_ovf    = 0;
        first_seen = 1'b0;
        bval       = 8'h11;
        rst_n      = 1'b1;
        repeat (2) @(negedge clk_100);
    endtask

    // Drives one line; the model decides emission and drop for each pixel.
    task automatic drive_line(input int ncols, input int row, input bit active);
        logic [7:0] pb[2];
        pix_t       e;
        @(negedge clk_100);
        cmos_pclk = 1'b0;
        cmos_href = 1'b1;
        repeat (4) @(negedge clk_100);
        for (int c = 0; c < ncols; c++) begin
            for (int b = 0; b < bpp; b++) begin
                cmos_pclk = 1'b0;
                cmos_db   = bval;
                pb[b]     = bval;
                bval      = bval + 8'h11;
                repeat (4) @(negedge clk_100);
                cmos_pclk = 1'b1;
                if (b == bpp - 1 && active &&
                    c >= int'(cx0) && c <= int'(cx1) &&
                    row >= int'(cy0) && row <= int'(cy1)) begin
                    e.data   = (bpp == 2) ? {pb[0], pb[1]} : {8'h00, pb[0]};
                    e.sof    = sof_pend;
                    e.eol    = (c == int'(cx1));
                    sof_pend = 1'b0;
                    if (exp_q.size() != 0 && !rdy) exp_ovf++;
                    else                          exp_q.push_back(e);
                end
                repeat (4) @(negedge clk_100);
            end
        end
        cmos_pclk = 1'b0;
        repeat (4) @(negedge clk_100);
        cmos_href = 1'b0;
        repeat (6) @(negedge clk_100);
    endtask

    task automatic vs_start();
        @(negedge clk_100);
        cmos_vsync = 1'b1;
        repeat (8) @(negedge clk_100);
        cmos_vsync = 1'b0;
        sof_pend   = 1'b1;
        repeat (8) @(negedge clk_100);
    endtask

    task automatic vs_end();
        @(negedge clk_100);
        cmos_vsync = 1'b1;
        repeat (8) @(negedge clk_100);
    endtask

    task automatic run_frame(input bit active, input int ncols, input int nrows, input int drop_row);
        vs_start();
        for (int r = 0; r < nrows; r++) begin
            drive_line(ncols, r, active);
            if (r == drop_row) set_en(1'b0);
        end
        vs_end();
    endtask

    initial begin
        n_checks = 0; n_err = 0; pop_count = 0; exp_ovf = 0;
        hold_prev = 1'b0; first_seen = 1'b0; sof_pend = 1'b0;
        sel = 1'b0; bpp = 2; rdy = 1'b1; decim = 4'd0;
        cx0 = 10'd0; cx1 = 10'd3; cy0 = 10'd0; cy1 = 10'd1;
        cmos_db = 8'h00; cmos_pclk = 1'b0; cmos_href = 1'b0; cmos_vsync = 1'b0;
        en_a = 1'b0; en_b = 1'b0; bval = 8'h11;

        //          sel  x0  x1  y0  y1  dec cols rows frm  pix frames first
        vecs[0] = '{1'b0, 10'd0, 10'd3, 10'd0, 10'd1, 4'd0, 4, 2, 1,  8, 16'd1, 16'h1122};
        vecs[1] = '{1'b0, 10'd0, 10'd3, 10'd0, 10'd1, 4'd2, 4, 2, 6, 16, 16'd2, 16'h1122};
        vecs[2] = '{1'b1, 10'd1, 10'd2, 10'd1, 10'd1, 4'd0, 4, 3, 1,  2, 16'd1, 16'h0066};
        vecs[3] = '{1'b0, 10'd3, 10'd1, 10'd0, 10'd1, 4'd0, 4, 2, 1,  0, 16'd1, 16'h0000};
        vecs[4] = '{1'b0, 10'd2, 10'd9, 10'd1, 10'd5, 4'd0, 4, 2, 1,  2, 16'd1, 16'hDDEE};

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk_100);
        #1;
        check("rst_valid", {31'd0, a_valid}, 32'd0);
        check("rst_data", {16'd0, a_data}, 32'd0);
        check("rst_busy", {31'd0, a_busy}, 32'd0);
        check("rst_frame", {16'd0, a_frame}, 32'd0);
        check("rst_ovf", {16'd0, a_ovf}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            sel = vecs[i].sel;
            bpp = sel ? 1 : 2;
            cx0 = vecs[i].x0; cx1 = vecs[i].x1; cy0 = vecs[i].y0; cy1 = vecs[i].y1;
            decim = vecs[i].dec;
            rdy = 1'b1;
            apply_reset();
            set_en(1'b1);
            repeat (2) @(negedge clk_100);
            for (int f = 0; f < vecs[i].nframes; f++)
                run_frame((f % (int'(vecs[i].dec) + 1)) == 0, vecs[i].ncols, vecs[i].nrows, -1);
            repeat (10) @(negedge clk_100);
            check($sformatf("v%0d_pixels", i), pop_count, vecs[i].exp_pix);
            check($sformatf("v%0d_frames", i), {16'd0, m_frame}, {16'd0, vecs[i].exp_frames});
            check($sformatf("v%0d_ovf", i), {16'd0, m_ovf}, exp_ovf);
            check($sformatf("v%0d_pending", i), exp_q.size(), 32'd0);
            check($sformatf("v%0d_busy", i), {31'd0, m_busy}, 32'd1);
            if (vecs[i].exp_pix > 0)
                check($sformatf("v%0d_first", i), {16'd0, first_data}, {16'd0, vecs[i].exp_first});
        end

        // Backpressure: one 4-pixel line with pix_ready low
        sel = 1'b0; bpp = 2; decim = 4'd0;
        cx0 = 10'd0; cx1 = 10'd3; cy0 = 10'd0; cy1 = 10'd0;
        rdy = 1'b0;
        apply_reset();
        en_a = 1'b1;
        repeat (2) @(negedge clk_100);
        vs_start();
        drive_line(4, 0, 1'b1);
        vs_end();
        repeat (5) @(negedge clk_100);
        check("bp_ovf", {16'd0, a_ovf}, 32'd3);
        check("bp_valid_held", {31'd0, a_valid}, 32'd1);
        check("bp_data_held", {16'd0, a_data}, 32'h1122);
        check("bp_no_pop", pop_count, 32'd0);
        rdy = 1'b1;
        repeat (6) @(negedge clk_100);
        check("bp_one_pop", pop_count, 32'd1);
        check("bp_valid_clear", {31'd0, a_valid}, 32'd0);
        check("bp_pending", exp_q.size(), 32'd0);

        // Disable mid-frame: frame completes, then IDLE
        cx0 = 10'd0; cx1 = 10'd3; cy0 = 10'd0; cy1 = 10'd1;
        rdy = 1'b1;
        apply_reset();
        en_a = 1'b1;
        repeat (2) @(negedge clk_100);
        run_frame(1'b1, 4, 2, 0);
        repeat (6) @(negedge clk_100);
        check("dis_pixels", pop_count, 32'd8);
        check("dis_busy", {31'd0, a_busy}, 32'd0);
        check("dis_frames", {16'd0, a_frame}, 32'd1);

        // Reset mid-frame
        apply_reset();
        en_a = 1'b1;
        repeat (2) @(negedge clk_100);
        run_frame(1'b1, 4, 2, -1);
        repeat (4) @(negedge clk_100);
        check("rmf_frames_pre", {16'd0, a_frame}, 32'd1);
        rdy = 1'b0;
        vs_start();
        drive_line(4, 0, 1'b1);
        check("rmf_valid_pre", {31'd0, a_valid}, 32'd1);
        check("rmf_ovf_pre", {16'd0, a_ovf}, exp_ovf);
        @(negedge clk_100);
        rst_n = 1'b0;
        #1;
        check("rmf_valid", {31'd0, a_valid}, 32'd0);
        check("rmf_data", {16'd0, a_data}, 32'd0);
        check("rmf_sof_eol", {30'd0, a_sof, a_eol}, 32'd0);
        check("rmf_busy", {31'd0, a_busy}, 32'd0);
        check("rmf_frame", {16'd0, a_frame}, 32'd0);
        check("rmf_ovf", {16'd0, a_ovf}, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk_100);
        rst_n = 1'b1;
        rdy = 1'b1;
        pc0 = pop_count;
        drive_line(4, 1, 1'b0);
        vs_end();
        repeat (6) @(negedge clk_100);
        check("rmf_no_partial", pop_count, pc0);
        run_frame(1'b1, 4, 2, -1);
        repeat (6) @(negedge clk_100);
        check("rmf_next_pixels", pop_count - pc0, 32'd8);
        check("rmf_next_frames", {16'd0, a_frame}, 32'd1);
        check("rmf_pending", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/cmos_pixel_capture.md
CMOS_PIXEL_CAPTURE -- requirements
Module: cmos_pixel_capture

Interface
REQ-001 Parameter BYTES_PER_PIXEL, default 2, meaning bytes per pixel: 1 for raw/Y8, 2 for RGB565/YUV422; other values are illegal.
REQ-002 Parameter CNT_W, default 10, meaning width of the column counter, row counter and crop bounds.
REQ-003 Port clk_100, input, 1 bit, system clock; all logic runs on it, and camera inputs are sampled on it.
REQ-004 Port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 Ports cmos_pclk, cmos_href, cmos_vsync, input, 1 bit each, raw camera timing, asynchronous to clk_100.
REQ-006 Port cmos_db, input, 8 bits, camera data bus.
REQ-007 Port enable, input, 1 bit, capture enable.
REQ-008 Port decim, input, 4 bits, frame decimation: capture 1 frame, then skip decim frames.
REQ-009 Ports crop_x0, crop_x1, crop_y0, crop_y1, input, CNT_W bits each, inclusive crop window in pixel/line coordinates.
REQ-010 Port pix_data, output, 8*BYTES_PER_PIXEL bits, assembled pixel with the first byte in the MSBs.
REQ-011 Ports pix_valid, pix_sof, pix_eol, output, 1 bit each: pixel valid, first pixel of frame, last pixel of line.
REQ-012 Port pix_ready, input, 1 bit, downstream accept.
REQ-013 Port frame_cnt, output, 16 bits, count of completed captured frames.
REQ-014 Port overflow_cnt, output, 16 bits, count of dropped pixels.
REQ-015 Port busy, output, 1 bit, high while state is not IDLE.

Function
REQ-016 Sync stages: pclk, href and vsync each pass through 2 flops (s1, s2); cmos_db is registered once, in parallel with s1.
REQ-017 Edge detection: pclk rise = s1 & ~s2; href fall = ~s1 & s2; vsync fall = ~s1 & s2; vsync rise = s1 & ~s2.
REQ-018 Byte capture: on a pclk rise with href s1 and s2 both high, store the registered cmos_db into the byte lane given by byte_idx, then increment byte_idx.
REQ-019 Pixel completion: when the last byte is stored, byte_idx returns to 0 and the pixel is complete; byte_idx is cleared on every href fall.
REQ-020 States are IDLE, WAIT_VS, ACTIVE, SKIP.
REQ-021 IDLE -> WAIT_VS when enable=1.
REQ-022 WAIT_VS -> ACTIVE on vsync fall if skip_cnt=0; WAIT_VS -> SKIP on vsync fall if skip_cnt!=0.
REQ-023 ACTIVE or SKIP -> WAIT_VS on vsync rise when enable=1, or -> IDLE on vsync rise when enable=0.
REQ-024 Leaving ACTIVE increments frame_cnt, wrapping at 16 bits.
REQ-025 skip_cnt control: entering ACTIVE loads skip_cnt with decim; entering SKIP decrements skip_cnt; decim=0 captures every frame.
REQ-026 enable=0 while in WAIT_VS returns to IDLE immediately; enable=0 while in ACTIVE or SKIP takes effect at the next vsync rise (a frame is never truncated).
REQ-027 Column counter col: increments per completed pixel and clears on href fall.
REQ-028 Row counter row: increments on href fall and clears on vsync fall.
REQ-029 col and row saturate at all-ones and never wrap.
REQ-030 A completed pixel is emitted only in ACTIVE with crop_x0<=col<=crop_x1 and crop_y0<=row<=crop_y1, using col/row values before the increment.
REQ-031 pix_sof=1 on the first emitted pixel after entering ACTIVE; pix_eol=1 when col==crop_x1.
REQ-032 If crop_x1<crop_x0 or crop_y1<crop_y0, nothing is emitted, but frames are still counted.
REQ-033 Output stage is a one-deep register; latency is 1 clk_100 cycle from the completing pclk-rise cycle to pix_valid=1.
REQ-034 Handshake: pix_valid, pix_data, pix_sof and pix_eol hold stable until pix_valid&pix_ready; pix_valid then clears unless a new pixel loads in the same cycle.
REQ-035 Drop rule: if a pixel is emitted while pix_valid=1 and pix_ready=0, the new pixel is dropped, the held pixel is kept, and overflow_cnt increments, saturating at 16'hFFFF.
REQ-036 Simultaneous accept and emit: when accept and a new emit occur in the same cycle, the new pixel loads with no drop.
REQ-037 Crop bounds and decim are sampled only on vsync fall; changes mid-frame have no effect until the next frame.

Reset
REQ-038 rst_n low asynchronously forces: state IDLE; sync flops 0; byte_idx, col, row and skip_cnt 0; pix_data 0; pix_valid, pix_sof, pix_eol and busy 0; frame_cnt and overflow_cnt 0.
REQ-039 Reset release mid-frame: capture starts only after a full vsync fall is observed, so a partial frame is never emitted.

Verification
REQ-040 Full frame: BPP=2, crop 0..3 x 0..1, 4-pixel x 2-line frame, bytes 8'h11,8'h22,... with pix_ready=1 -> 8 pixels (16'h1122 first), sof on pixel 0, eol on pixels 3 and 7, frame_cnt=1.
REQ-041 Backpressure: pix_ready=0 for a 4-pixel line -> first pixel held stable, overflow_cnt=3, then pix_ready=1 -> held pixel accepted once.
REQ-042 Decimation: decim=2 over 6 frames -> frames 0 and 3 emitted, frame_cnt=2, no pixels while in SKIP.
REQ-043 Crop: crop 1..2 x 1..1 on a 4x3 frame, BPP=1 -> exactly 2 pixels emitted, from row 1 columns 1 and 2, sof on the first, eol on the second.
REQ-044 Disable mid-frame: enable drops during ACTIVE -> remaining pixels of the current frame are emitted, then IDLE, busy=0, frame_cnt+1.
REQ-045 Reset mid-frame: rst_n pulse during ACTIVE -> all outputs 0 at once; after release, no pixel until the next vsync fall.
